// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file and its
// soft-clear sequencer.
package reg_file_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    // Address width for a given depth; never narrower than one bit.
    function automatic int rf_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Soft-clear sequencer: walks an index across every entry, one per cycle,
// while the array is held off from normal writes.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = rf_addr_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    output logic             busy,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_index,
    output rf_state_t        state
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    // A clear request seen while already sweeping is ignored; no restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clr_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state     <= CLEAR;
                        clr_index <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_index == LAST) begin
                        state     <= IDLE;
                        clr_index <= '0;
                    end else begin
                        clr_index <= clr_index + IDX_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    clr_index <= '0;
                end
            endcase
        end
    end

    assign busy   = (state == CLEAR);
    assign clr_en = (state == CLEAR);

endmodule

// File: rtl/reg_file_param.sv
// Two-read/one-write register file with registered reads, write-first bypass,
// optional hardwired zero entry and a multi-cycle soft clear.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = rf_addr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic              clear,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [WIDTH-1:0]  write_data,
    output logic [WIDTH-1:0]  data1,
    output logic [WIDTH-1:0]  data2,
    output logic              valid,
    output logic              busy,
    output logic              error
);

    // One extra bit so a full power-of-two depth still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_index;
    rf_state_t         state;
    logic              wr_ok;
    logic              wr_err;
    logic              rd_err;
    logic [WIDTH-1:0]  stored1;
    logic [WIDTH-1:0]  stored2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Priority: out of range, zero register, sweep in progress, bypass, array.
    function automatic logic [WIDTH-1:0] port_value(
        input logic [ADDR_W-1:0] a,
        input logic [WIDTH-1:0]  stored,
        input logic              clearing,
        input logic              bypass_en,
        input logic [ADDR_W-1:0] bypass_addr,
        input logic [WIDTH-1:0]  bypass_data
    );
        if (!in_range(a) || is_zero_reg(a) || clearing) return '0;
        if (bypass_en && (bypass_addr == a)) return bypass_data;
        return stored;
    endfunction

    reg_file_clear_seq #(
        .DEPTH (DEPTH),
        .IDX_W (ADDR_W)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_index (clr_index),
        .state     (state)
    );

    always_comb begin
        wr_ok   = write && (state == IDLE) && in_range(write_address) && !is_zero_reg(write_address);
        wr_err  = write && ((state != IDLE) || !in_range(write_address));
        rd_err  = read && (!in_range(address1) || !in_range(address2));
        stored1 = '0;
        stored2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (address1 == ADDR_W'(i)) stored1 = mem[i];
            if (address2 == ADDR_W'(i)) stored2 = mem[i];
        end
        rd1 = port_value(address1, stored1, state == CLEAR, wr_ok, write_address, write_data);
        rd2 = port_value(address2, stored2, state == CLEAR, wr_ok, write_address, write_data);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_en && (clr_index == ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr_ok && (write_address == ADDR_W'(i))) begin
                    mem[i] <= write_data;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data1 <= '0;
            data2 <= '0;
            valid <= 1'b0;
            error <= 1'b0;
        end else begin
            valid <= read;
            error <= wr_err || rd_err;
            if (read) begin
                data1 <= rd1;
                data2 <= rd2;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: one 8-entry instance and one 6-entry instance with
// a hardwired zero register, driven by shared inputs and checked against models.
module tb_reg_file_param;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic        clear;
    logic [2:0]  address1;
    logic [2:0]  address2;
    logic [2:0]  write_address;
    logic [15:0] write_data;
    logic [15:0] d1_a, d2_a, d1_b, d2_b;
    logic        v_a, b_a, e_a, v_b, b_b, e_b;

    int checks = 0;
    int errors = 0;

    reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut_a (
        .clock(clock), .reset(reset), .read(read), .write(write), .clear(clear),
        .address1(address1), .address2(address2), .write_address(write_address),
        .write_data(write_data), .data1(d1_a), .data2(d2_a),
        .valid(v_a), .busy(b_a), .error(e_a)
    );

    reg_file_param #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) dut_b (
        .clock(clock), .reset(reset), .read(read), .write(write), .clear(clear),
        .address1(address1), .address2(address2), .write_address(write_address),
        .write_data(write_data), .data1(d1_b), .data2(d2_b),
        .valid(v_b), .busy(b_b), .error(e_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int          m_depth [2];
    int          m_zr    [2];
    logic [15:0] m_mem   [2][8];
    int          m_left  [2];
    logic [15:0] m_d1    [2];
    logic [15:0] m_d2    [2];
    logic        m_v     [2];
    logic        m_e     [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0;
            m_left[k] = 0;
            m_d1[k]   = 16'h0;
            m_d2[k]   = 16'h0;
            m_v[k]    = 1'b0;
            m_e[k]    = 1'b0;
        end
    endtask

    function automatic logic [15:0] model_port(input int k, input int a, input logic w,
                                               input int wa, input logic [15:0] wd);
        if (a >= m_depth[k]) return 16'h0;
        if (m_zr[k] != 0 && a == 0) return 16'h0;
        if (m_left[k] > 0) return 16'h0;
        if (w && wa == a) return wd;
        return m_mem[k][a];
    endfunction

    task automatic model_step(input int k, input logic r, input logic w, input logic c,
                              input int a1, input int a2, input int wa, input logic [15:0] wd);
        logic err;
        int   left0;
        err   = 1'b0;
        left0 = m_left[k];
        if (r) begin
            m_d1[k] = model_port(k, a1, w, wa, wd);
            m_d2[k] = model_port(k, a2, w, wa, wd);
            m_v[k]  = 1'b1;
            if (a1 >= m_depth[k] || a2 >= m_depth[k]) err = 1'b1;
        end else begin
            m_v[k] = 1'b0;
        end
        if (w) begin
            if (left0 > 0 || wa >= m_depth[k]) err = 1'b1;
            else if (!(m_zr[k] != 0 && wa == 0)) m_mem[k][wa] = wd;
        end
        if (left0 > 0) begin
            m_mem[k][m_depth[k] - left0] = 16'h0;
            m_left[k] = left0 - 1;
        end else if (c) begin
            m_left[k] = m_depth[k];
        end
        m_e[k] = err;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_models();
        check("a.data1", d1_a, m_d1[0]);
        check("a.data2", d2_a, m_d2[0]);
        check("a.valid", {15'h0, v_a}, {15'h0, m_v[0]});
        check("a.error", {15'h0, e_a}, {15'h0, m_e[0]});
        check("a.busy",  {15'h0, b_a}, {15'h0, m_left[0] > 0});
        check("b.data1", d1_b, m_d1[1]);
        check("b.data2", d2_b, m_d2[1]);
        check("b.valid", {15'h0, v_b}, {15'h0, m_v[1]});
        check("b.error", {15'h0, e_b}, {15'h0, m_e[1]});
        check("b.busy",  {15'h0, b_b}, {15'h0, m_left[1] > 0});
    endtask

    // Drives one cycle of inputs, waits past the edge, then checks both DUTs.
    task automatic step(input logic r, input logic w, input logic c,
                        input int a1, input int a2, input int wa, input logic [15:0] wd);
        read          = r;
        write         = w;
        clear         = c;
        address1      = 3'(a1);
        address2      = 3'(a2);
        write_address = 3'(wa);
        write_data    = wd;
        @(posedge clock);
        #1;
        model_step(0, r, w, c, a1, a2, wa, wd);
        model_step(1, r, w, c, a1, a2, wa, wd);
        compare_models();
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic        c;
        int          a1;
        int          a2;
        int          wa;
        logic [15:0] wd;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        ev;
        logic        ee;
    } vec_t;

    vec_t vecs[$];
    int   cnt_a;
    int   cnt_b;

    initial begin
        m_depth[0] = 8; m_zr[0] = 0;
        m_depth[1] = 6; m_zr[1] = 1;
        model_reset();

        // Expected values below are for the 8-entry instance.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 3, 5, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0, 0, 2, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2, 0, 0, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2, 4, 4, 16'h1234, 16'hBEEF, 16'h1234, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h0000, 16'hBEEF, 16'h1234, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4, 7, 0, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 7, 7, 7, 16'h0A0A, 16'h0A0A, 16'h0A0A, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0, 0, 0, 16'hFFFF, 16'h0A0A, 16'h0A0A, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 0, 2, 0, 16'h0000, 16'hFFFF, 16'hBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 7, 2, 0, 16'h0000, 16'h0A0A, 16'hBEEF, 1'b1, 1'b0});

        // Clock/reset
        reset = 1'b1; read = 1'b0; write = 1'b0; clear = 1'b0;
        address1 = '0; address2 = '0; write_address = '0; write_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset.a.data1", d1_a, 16'h0);
        check("reset.a.data2", d2_a, 16'h0);
        check("reset.a.flags", {13'h0, v_a, b_a, e_a}, 16'h0);
        check("reset.b.flags", {13'h0, v_b, b_b, e_b}, 16'h0);
        reset = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].w, vecs[i].c, vecs[i].a1, vecs[i].a2, vecs[i].wa, vecs[i].wd);
            check($sformatf("vec%0d.data1", i), d1_a, vecs[i].e1);
            check($sformatf("vec%0d.data2", i), d2_a, vecs[i].e2);
            check($sformatf("vec%0d.valid", i), {15'h0, v_a}, {15'h0, vecs[i].ev});
            check($sformatf("vec%0d.error", i), {15'h0, e_a}, {15'h0, vecs[i].ee});
        end

        // Out-of-range write/read on the 6-entry instance
        step(1'b0, 1'b1, 1'b0, 0, 0, 7, 16'h7777);
        check("b.oor_write.error", {15'h0, e_b}, 16'h1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h0);
        check("b.error_pulse", {15'h0, e_b}, 16'h0);
        step(1'b1, 1'b0, 1'b0, 7, 1, 0, 16'h0);
        check("b.oor_read.data1", d1_b, 16'h0);
        check("b.oor_read.error", {15'h0, e_b}, 16'h1);

        // Hardwired zero register
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, 16'hFFFF);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 16'h0);
        check("b.zero_reg.data1", d1_b, 16'h0);
        check("b.zero_reg.error", {15'h0, e_b}, 16'h0);

        // Fill, then clear together with a write, then write during the sweep
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 0, 0, i, 16'h1100 + 16'(i));
        step(1'b0, 1'b1, 1'b1, 0, 0, 3, 16'h5555);
        check("clear_with_write.error", {15'h0, e_a}, 16'h0);
        cnt_a = b_a ? 1 : 0;
        cnt_b = b_b ? 1 : 0;
        step(1'b0, 1'b1, 1'b1, 0, 0, 1, 16'h9999);
        check("write_in_clear.error", {15'h0, e_a}, 16'h1);
        if (b_a) cnt_a++;
        if (b_b) cnt_b++;
        for (int n = 0; n < 20 && (b_a || b_b); n++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h0);
            if (b_a) cnt_a++;
            if (b_b) cnt_b++;
        end
        check("clear.done", {14'h0, b_a, b_b}, 16'h0);
        check("a.busy_cycles", 16'(cnt_a), 16'd8);
        check("b.busy_cycles", 16'(cnt_b), 16'd6);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, i, 7 - i, 0, 16'h0);
            check($sformatf("cleared%0d", i), d1_a, 16'h0);
        end

        // Asynchronous reset in the middle of a sweep
        step(1'b0, 1'b0, 1'b1, 0, 0, 0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 16'h0);
        check("mid_clear.busy", {15'h0, b_a}, 16'h1);
        #2 reset = 1'b1;
        #1;
        check("async_reset.busy", {14'h0, b_a, b_b}, 16'h0);
        check("async_reset.valid", {14'h0, v_a, v_b}, 16'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 24) == 0),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised two-read/one-write register file for the datapath: clocked, with registered read outputs, write-to-read bypass and an optional hardwired zero register. It also has a multi-cycle soft-clear sequencer, so the array can be wiped without asserting reset. It sits between the decoder, which supplies addresses, and the ALU operand muxes, which consume `data1`/`data2`.

## Interface
- `WIDTH`, 16: data bits per entry
- `DEPTH`, 8: number of entries, 2..256, need not be a power of two
- `ZERO_REG`, 0: 1 = entry 0 always reads 0 and ignores writes
- `ADDR_W`, derived `$clog2(DEPTH)` (min 1): address width, not overridable
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `read` in 1: read strobe for both read ports
- `write` in 1: write strobe
- `clear` in 1: request soft clear (single-cycle pulse or level)
- `address1` in ADDR_W: read port 1 address
- `address2` in ADDR_W: read port 2 address
- `write_address` in ADDR_W: write address
- `write_data` in WIDTH: write data
- `data1` out WIDTH: read port 1 result
- `data2` out WIDTH: read port 2 result
- `valid` out 1: `data1`/`data2` updated this cycle
- `busy` out 1: soft clear in progress
- `error` out 1: one-cycle flag for a rejected access

## Operation
- Reset (async): all entries, `data1`, `data2`, `valid`, `busy`, `error` go to 0; FSM goes to IDLE; clear index goes to 0.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR when `clear`=1; index loads 0.
  - In CLEAR, one entry per cycle is zeroed at `index`, then index increments.
  - CLEAR→IDLE on the edge that zeroes entry DEPTH-1.
  - `clear` asserted while already in CLEAR is ignored; there is no restart.
- Write (IDLE only): `write`=1 with `write_address`<DEPTH stores `write_data` on the edge.
  - Address ≥DEPTH: no store, `error`=1 next cycle.
  - `write` in CLEAR: no store, `error`=1 next cycle.
  - `ZERO_REG`=1 and address 0: silently dropped, no error.
- Read: `read`=1 registers both ports on the edge and `valid`=1 next cycle. Each port is resolved in this order:
  - address ≥DEPTH → 0, and `error`=1;
  - `ZERO_REG` and address 0 → 0;
  - FSM in CLEAR → 0;
  - a write accepted the same cycle to the same address → `write_data` (bypass, write-first);
  - otherwise the stored entry.
- `read`=0: `data1`/`data2` hold their previous values; `valid`=0.
- `error` is the OR of all rejection causes in the sampled cycle. It is a pulse, not sticky.
- `clear` and `write` in the same IDLE cycle: the write is performed, then the sweep begins next cycle and erases it. `error` stays 0.

## Timing
- Read latency: 1 cycle, address sampled at edge N, data and `valid` after edge N.
- Write visible to a non-bypassed read issued the following cycle.
- `busy`=1 for exactly DEPTH cycles, starting the cycle after `clear` is sampled.
- Reset asserted mid-CLEAR aborts immediately.
- After reset deasserts, the first edge may accept a read or write.

## Structure
- The shared package `reg_file_pkg` holds:
  - the FSM state enum `rf_state_t` {IDLE, CLEAR};
  - the function `rf_addr_w(depth)` used for `ADDR_W`.
- One sub-module, `reg_file_clear_seq`: the FSM plus index counter, with outputs `busy`, `clr_en`, `clr_index`.
- Array, bypass and error logic stay in the top module.

## Test plan
- Reset then read, `address1`=3, `address2`=5 → after 1 cycle `data1`=`data2`=0, `valid`=1.
- Write 0xBEEF→entry 2. Next cycle read `address1`=2 → `data1`=0xBEEF one cycle later.
- Same-cycle write 0x1234→entry 4 and read `address2`=4 → `data2`=0x1234 (bypass).
- DEPTH=6: write to address 7 → `error` pulses 1 cycle; a subsequent read of 7 → `data1`=0, `error`=1.
- Fill all entries, pulse `clear` → `busy` high exactly 8 cycles (DEPTH=8). A write during that window → `error`. Afterwards all entries read 0.
- `ZERO_REG`=1: write 0xFFFF→entry 0, read 0 → `data1`=0 and no `error`. Async reset asserted mid-CLEAR → `busy`=0 immediately.
